// File: rtl/posture_judge.sv
// Neck-posture alarm judge: warm-up blanking, consecutive-sample confirmation and hysteresis release.
// Optional buzzer square wave on `beep` when NECK_BEEP_EN is defined.
module posture_judge #(
  parameter int                         DATA_W    = 13,
  parameter logic signed [DATA_W-1:0]   TH_HIGH   = 13'sd2500,
  parameter logic signed [DATA_W-1:0]   TH_LOW    = 13'sd2300,
  parameter int                         N_CONFIRM = 8,
  parameter int                         N_RELEASE = 4,
  parameter int                         N_WARMUP  = 16,
  parameter int                         BEEP_HALF = 25000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] filtered_data,
  input  logic                     filter_finish,
  output logic                     alarm,
  output logic                     alarm_rise,
  output logic signed [DATA_W-1:0] peak_data,
  output logic [2:0]               state_o
`ifdef NECK_BEEP_EN
  ,
  output logic                     beep
`endif
);

  typedef enum logic [2:0] {
    WARMUP  = 3'd0,
    NORMAL  = 3'd1,
    SUSPECT = 3'd2,
    ALARM   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  if (TH_LOW >= TH_HIGH || N_CONFIRM < 2 || N_CONFIRM > 255 || N_RELEASE < 2 ||
      N_RELEASE > 255 || N_WARMUP < 1 || N_WARMUP > 255 || BEEP_HALF < 1) begin : g_param_check
    $error("posture_judge: parameter out of range");
  end

  state_t                     state;
  logic [7:0]                 cnt;
  logic [7:0]                 wcnt;
  logic [8:0]                 cnt_inc;
  logic [8:0]                 wcnt_inc;
  logic                       is_bad;
  logic                       is_good;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign is_bad   = filtered_data > TH_HIGH;
  assign is_good  = filtered_data < TH_LOW;
  assign cnt_inc  = {1'b0, cnt} + 9'd1;
  assign wcnt_inc = {1'b0, wcnt} + 9'd1;
  assign state_o  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WARMUP;
      cnt        <= '0;
      wcnt       <= '0;
      alarm      <= 1'b0;
      alarm_rise <= 1'b0;
      peak_data  <= '0;
    end else begin
      alarm_rise <= 1'b0;
      if (filter_finish) begin
        case (state)
          WARMUP: begin
            wcnt <= wcnt_inc[7:0];
            if (wcnt_inc == 9'(N_WARMUP)) state <= NORMAL;
          end
          NORMAL: begin
            if (is_bad) begin
              state <= SUSPECT;
              cnt   <= 8'd1;
            end
          end
          SUSPECT: begin
            if (is_bad) begin
              if (cnt_inc == 9'(N_CONFIRM)) begin
                state      <= ALARM;
                cnt        <= '0;
                alarm      <= 1'b1;
                alarm_rise <= 1'b1;
                peak_data  <= filtered_data;
              end else begin
                cnt <= cnt_inc[7:0];
              end
            end else begin
              state <= NORMAL;
              cnt   <= '0;
            end
          end
          ALARM: begin
            peak_data <= smax(peak_data, filtered_data);
            if (is_good) begin
              state <= RELEASE;
              cnt   <= 8'd1;
            end
          end
          RELEASE: begin
            peak_data <= smax(peak_data, filtered_data);
            if (is_good) begin
              if (cnt_inc == 9'(N_RELEASE)) begin
                state <= NORMAL;
                alarm <= 1'b0;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc[7:0];
              end
            end else begin
              // hysteresis-band or bad sample aborts the release run
              state <= ALARM;
              cnt   <= '0;
            end
          end
          default: begin
            state <= WARMUP;
            cnt   <= '0;
            wcnt  <= '0;
            alarm <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef NECK_BEEP_EN
  localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  logic [BW-1:0] bcnt;

  // Counter is held at 0 while alarm is low, so it starts from 0 in the alarm_rise cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
      beep <= 1'b0;
    end else if (!alarm) begin
      bcnt <= '0;
      beep <= 1'b0;
    end else if (bcnt == BW'(BEEP_HALF - 1)) begin
      bcnt <= '0;
      beep <= ~beep;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`endif

endmodule
